// File: rtl/clock_core.sv
// Hour/minute/second timekeeper with run and set modes.
// Buttons are synchronized, edge-detected and applied per field.
module clock_core #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic [5:0] operator,
  output logic [5:0] second,
  output logic [5:0] minute,
  output logic [4:0] hour,
  output logic       sec_tick,
  output logic [7:0] second_bcd,
  output logic [7:0] minute_bcd,
  output logic [7:0] hour_bcd
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] TC = PW'(TICKS_PER_SEC - 1);

  logic             mode_s1_q, mode_s2_q;
  logic [5:0]       op_s1_q, op_s2_q, op_prev_q;
  logic [5:0]       armed_q, armed_d, ev;
  logic [1:0]       fill_q, fill_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [5:0]       sec_q, sec_d, min_q, min_d;
  logic [4:0]       hr_q, hr_d;
  logic             tick_q, tick_d;

  function automatic logic [5:0] step(
    input logic [5:0] v,
    input logic [5:0] max,
    input logic       up,
    input logic       dn
  );
    logic [5:0] r;
    r = v;
    if (up && !dn)
      r = (v >= max) ? 6'd0 : v + 6'd1;
    else if (dn && !up)
      r = (v == 6'd0 || v > max) ? max : v - 6'd1;
    return r;
  endfunction

  function automatic logic [7:0] bcd(input logic [5:0] v);
    logic [3:0] t;
    logic [5:0] r;
    t = 4'd0;
    r = v;
    for (int i = 0; i < 6; i++) begin
      if (r >= 6'd10) begin
        r = r - 6'd10;
        t = t + 4'd1;
      end
    end
    return {t, 4'(r)};
  endfunction

  // A bit arms only after a genuine synchronized high, so a button
  // held low through reset release cannot fake a falling edge.
  always_comb begin
    ev      = armed_q & op_prev_q & ~op_s2_q;
    fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    armed_d = armed_q | ({6{fill_q == 2'd2}} & op_s2_q);
    presc_d = presc_q;
    tick_d  = 1'b0;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    if (mode_s2_q) begin
      presc_d = '0;
      sec_d   = step(sec_q, 6'd59, ev[0], ev[1]);
      min_d   = step(min_q, 6'd59, ev[2], ev[3]);
      hr_d    = 5'(step({1'b0, hr_q}, 6'd23, ev[4], ev[5]));
    end else if (presc_q == TC) begin
      presc_d = '0;
      tick_d  = 1'b1;
      sec_d   = step(sec_q, 6'd59, 1'b1, 1'b0);
      if (sec_q == 6'd59) begin
        min_d = step(min_q, 6'd59, 1'b1, 1'b0);
        if (min_q == 6'd59)
          hr_d = 5'(step({1'b0, hr_q}, 6'd23, 1'b1, 1'b0));
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1_q <= 1'b0;
      mode_s2_q <= 1'b0;
      op_s1_q   <= 6'h3F;
      op_s2_q   <= 6'h3F;
      op_prev_q <= 6'h3F;
      armed_q   <= 6'h00;
      fill_q    <= 2'd0;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      sec_q     <= 6'd0;
      min_q     <= 6'd0;
      hr_q      <= 5'd0;
    end else begin
      mode_s1_q <= mode;
      mode_s2_q <= mode_s1_q;
      op_s1_q   <= operator;
      op_s2_q   <= op_s1_q;
      op_prev_q <= op_s2_q;
      armed_q   <= armed_d;
      fill_q    <= fill_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hr_q      <= hr_d;
    end
  end

  assign second     = sec_q;
  assign minute     = min_q;
  assign hour       = hr_q;
  assign sec_tick   = tick_q;
  assign second_bcd = bcd(sec_q);
  assign minute_bcd = bcd(min_q);
  assign hour_bcd   = bcd({1'b0, hr_q});

endmodule

// File: tb/tb_clock_core.sv
// Directed bench for clock_core at four clocks per second.
// Set-mode presses come from a vector table; the rest are sequences.
module tb_clock_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [5:0] operator;
  logic [5:0] second, minute;
  logic [4:0] hour;
  logic       sec_tick;
  logic [7:0] second_bcd, minute_bcd, hour_bcd;

  int total = 0;
  int bad   = 0;

  clock_core #(.TICKS_PER_SEC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .operator   (operator),
    .second     (second),
    .minute     (minute),
    .hour       (hour),
    .sec_tick   (sec_tick),
    .second_bcd (second_bcd),
    .minute_bcd (minute_bcd),
    .hour_bcd   (hour_bcd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] mask;
    int         hold;
    int         s;
    int         m;
    int         h;
    logic [7:0] sbcd;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 'h%0h want 'h%0h", nm, act, exp);
    end
  endtask

  task automatic press(input logic [5:0] mask, input int hold);
    @(negedge clk);
    operator = ~mask;
    repeat (hold) @(negedge clk);
    operator = 6'h3F;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    int first;

    tbl[0]  = '{6'b000010, 1,  2,  0,  0, 8'h02};
    tbl[1]  = '{6'b000001, 3,  3,  0,  0, 8'h03};
    tbl[2]  = '{6'b001000, 2,  3, 59,  0, 8'h03};
    tbl[3]  = '{6'b100000, 1,  3, 59, 23, 8'h03};
    tbl[4]  = '{6'b000100, 1,  3,  0, 23, 8'h03};
    tbl[5]  = '{6'b001000, 1,  3, 59, 23, 8'h03};
    tbl[6]  = '{6'b000011, 1,  3, 59, 23, 8'h03};
    tbl[7]  = '{6'b010001, 1,  4, 59,  0, 8'h04};
    tbl[8]  = '{6'b100000, 1,  4, 59, 23, 8'h04};
    tbl[9]  = '{6'b101010, 1,  3, 58, 22, 8'h03};
    tbl[10] = '{6'b010101, 1,  4, 59, 23, 8'h04};
    tbl[11] = '{6'b000010, 1,  3, 59, 23, 8'h03};
    tbl[12] = '{6'b000010, 1,  2, 59, 23, 8'h02};
    tbl[13] = '{6'b000010, 1,  1, 59, 23, 8'h01};
    tbl[14] = '{6'b000010, 1,  0, 59, 23, 8'h00};
    tbl[15] = '{6'b000010, 5, 59, 59, 23, 8'h59};
    tbl[16] = '{6'b010000, 1, 59, 59,  0, 8'h59};
    tbl[17] = '{6'b110000, 1, 59, 59,  0, 8'h59};
    tbl[18] = '{6'b100000, 1, 59, 59, 23, 8'h59};

    rst_n    = 1'b0;
    mode     = 1'b0;
    operator = 6'h3F;
    repeat (3) @(negedge clk);
    chk("rst_sec",  second,   0);
    chk("rst_min",  minute,   0);
    chk("rst_hour", hour,     0);
    chk("rst_tick", sec_tick, 0);
    chk("rst_hbcd", hour_bcd, 8'h00);

    @(negedge clk);
    rst_n = 1'b1;
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("run_tick%0d", i), sec_tick, (i % 4 == 3) ? 1 : 0);
      if (sec_tick) ticks++;
    end
    chk("run_sec",   second, 3);
    chk("run_ticks", ticks,  3);

    @(negedge clk);
    mode = 1'b1;
    repeat (6) @(negedge clk);

    for (int v = 0; v < 19; v++) begin
      press(tbl[v].mask, tbl[v].hold);
      chk($sformatf("v%0d_sec",  v), second,     tbl[v].s);
      chk($sformatf("v%0d_min",  v), minute,     tbl[v].m);
      chk($sformatf("v%0d_hour", v), hour,       tbl[v].h);
      chk($sformatf("v%0d_sbcd", v), second_bcd, tbl[v].sbcd);
    end

    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sec_tick) ticks++;
    end
    chk("set_ticks", ticks, 0);
    chk("pre_hbcd", hour_bcd,   8'h23);
    chk("pre_mbcd", minute_bcd, 8'h59);

    @(negedge clk);
    mode  = 1'b0;
    first = 0;
    for (int c = 1; c <= 20 && first == 0; c++) begin
      @(negedge clk);
      if (sec_tick) first = c;
    end
    chk("first_tick", first,      6);
    chk("wrap_sec",   second,     0);
    chk("wrap_min",   minute,     0);
    chk("wrap_hour",  hour,       0);
    chk("wrap_sbcd",  second_bcd, 8'h00);
    chk("wrap_mbcd",  minute_bcd, 8'h00);
    chk("wrap_hbcd",  hour_bcd,   8'h00);

    press(6'b000100, 2);
    chk("run_press_min", minute, 0);

    @(negedge clk);
    operator[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    mode  = 1'b1;
    #1;
    chk("mid_rst_sec",  second,     0);
    chk("mid_rst_tick", sec_tick,   0);
    chk("mid_rst_sbcd", second_bcd, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("held_sec", second, 0);
    operator = 6'h3F;
    repeat (4) @(negedge clk);
    chk("release_sec", second, 0);
    press(6'b000001, 1);
    chk("repress_sec", second, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
